// File: rtl/ad7265_serial_if_pkg.sv
// Shared constants and types for the AD7265 dual-channel serial front end.
package ad7265_serial_if_pkg;

  localparam int AD7265_DATA_W          = 12;
  localparam int AD7265_SCLKS_PER_FRAME = 16;
  localparam int AD7265_FIRST_BIT_SCLK  = 2;
  localparam int AD7265_LAST_BIT_SCLK   = 13;

  typedef logic [AD7265_DATA_W-1:0] adc12_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CONVERT,
    ST_QUIET
  } state_t;

  // Mux addresses 0 and 7 are treated as no-op requests.
  function automatic logic addr_valid(input logic [2:0] a);
    return (a != 3'd0) && (a != 3'd7);
  endfunction

endpackage

// File: rtl/ad7265_serial_if_shift_in.sv
// MSB-first shift register collecting one ADC channel word while shift_en is high.
module ad7265_shift_in
  import ad7265_serial_if_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     din,
  output logic [AD7265_DATA_W-1:0] q
);

  adc12_t sr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg <= '0;
    end else if (shift_en) begin
      sr_reg <= {sr_reg[AD7265_DATA_W-2:0], din};
    end
  end

  assign q = sr_reg;

endmodule

// File: rtl/ad7265_serial_if.sv
// AD7265 frame sequencer: one req/rdy handshake runs one 16-SCLK frame and
// returns the simultaneous A/B conversion results.
module ad7265_serial_if
  import ad7265_serial_if_pkg::*;
#(
  parameter int   HALF_PERIOD  = 2,
  parameter int   QUIET_CYCLES = 4,
  parameter logic RANGE_SEL    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  addr,
  output logic        rdy,
  output logic [11:0] data_a,
  output logic [11:0] data_b,
  output logic        adc_sclk,
  output logic [2:0]  adc_addr,
  output logic        adc_ncs,
  output logic        adc_rng,
  input  logic        adc_a,
  input  logic        adc_b
);

  localparam logic [15:0] HALF_LAST  = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] SETUP_LAST = 16'(HALF_PERIOD);
  localparam logic [15:0] QUIET_LAST = 16'(QUIET_CYCLES - 1);
  localparam logic [4:0]  BIT_FIRST  = 5'(AD7265_FIRST_BIT_SCLK - 1);
  localparam logic [4:0]  BIT_LAST   = 5'(AD7265_LAST_BIT_SCLK - 1);
  localparam logic [4:0]  SCLK_LAST  = 5'(AD7265_SCLKS_PER_FRAME - 1);

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [4:0]  sclk_idx_reg;
  logic        rdy_reg;
  logic        sclk_reg;
  logic        ncs_reg;
  logic [2:0]  addr_reg;
  adc12_t      data_a_reg;
  adc12_t      data_b_reg;

  logic        shift_en;
  logic [1:0]  din_ch;
  adc12_t      sr_q [2];

  // Capture happens on the edge that ends the low half, i.e. the one raising SCLK.
  assign shift_en = (state_reg == ST_CONVERT) && !sclk_reg && (cnt_reg == HALF_LAST) &&
                    (sclk_idx_reg >= BIT_FIRST) && (sclk_idx_reg <= BIT_LAST);
  assign din_ch   = {adc_b, adc_a};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      ad7265_shift_in u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .din      (din_ch[gi]),
        .q        (sr_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      sclk_idx_reg <= '0;
      rdy_reg      <= 1'b0;
      sclk_reg     <= 1'b1;
      ncs_reg      <= 1'b1;
      addr_reg     <= '0;
      data_a_reg   <= '0;
      data_b_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rdy_reg && req && addr_valid(addr)) begin
            addr_reg  <= addr;
            rdy_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= ST_SETUP;
          end else begin
            rdy_reg <= 1'b1;
          end
        end
        // Address setup spans one cycle more than a half period so the
        // acceptance-to-result latency is 1 + 33*HALF_PERIOD + QUIET_CYCLES.
        ST_SETUP: begin
          if (cnt_reg == SETUP_LAST) begin
            cnt_reg      <= '0;
            sclk_idx_reg <= '0;
            ncs_reg      <= 1'b0;
            sclk_reg     <= 1'b0;
            state_reg    <= ST_CONVERT;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        ST_CONVERT: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!sclk_reg) begin
              sclk_reg <= 1'b1;
            end else if (sclk_idx_reg == SCLK_LAST) begin
              ncs_reg   <= 1'b1;
              state_reg <= ST_QUIET;
            end else begin
              sclk_reg     <= 1'b0;
              sclk_idx_reg <= sclk_idx_reg + 5'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        ST_QUIET: begin
          if (cnt_reg == QUIET_LAST) begin
            data_a_reg <= sr_q[0];
            data_b_reg <= sr_q[1];
            rdy_reg    <= 1'b1;
            cnt_reg    <= '0;
            state_reg  <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rdy      = rdy_reg;
  assign data_a   = data_a_reg;
  assign data_b   = data_b_reg;
  assign adc_sclk = sclk_reg;
  assign adc_ncs  = ncs_reg;
  assign adc_addr = addr_reg;
  assign adc_rng  = RANGE_SEL;

endmodule

// File: tb/tb_ad7265_serial_if.sv
// Bench for ad7265_serial_if: behavioural AD7265 model plus a result scoreboard.
module tb_ad7265_serial_if;

  localparam int HP = 2;
  localparam int QC = 4;
  localparam int LAT = 1 + 33 * HP + QC;

  logic        clk;
  logic        rst;
  logic        req;
  logic [2:0]  addr;
  logic        rdy;
  logic [11:0] data_a;
  logic [11:0] data_b;
  logic        adc_sclk;
  logic [2:0]  adc_addr;
  logic        adc_ncs;
  logic        adc_rng;
  logic        adc_a;
  logic        adc_b;

  ad7265_serial_if #(.HALF_PERIOD(HP), .QUIET_CYCLES(QC), .RANGE_SEL(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .addr     (addr),
    .rdy      (rdy),
    .data_a   (data_a),
    .data_b   (data_b),
    .adc_sclk (adc_sclk),
    .adc_addr (adc_addr),
    .adc_ncs  (adc_ncs),
    .adc_rng  (adc_rng),
    .adc_a    (adc_a),
    .adc_b    (adc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] sb [$];
  logic [11:0] model_a = '0;
  logic [11:0] model_b = '0;
  logic [11:0] last_a  = '0;
  logic [11:0] last_b  = '0;

  // ADC model and pin monitors, evaluated 1 time unit after each clk edge.
  logic        prev_ncs = 1'b1;
  logic        prev_sclk = 1'b1;
  int          bit_idx = 0;
  int          sclk_rises = 0;
  int          ncs_low_cycles = 0;
  int          high_run = 0;
  int          last_high_run = 0;
  int          toggles = 0;
  int          frames = 0;
  logic [2:0]  addr_at_fall = '0;
  logic [15:0] fa;
  logic [15:0] fb;

  initial begin
    adc_a = 1'b0;
    adc_b = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (prev_ncs && !adc_ncs) begin
      bit_idx        = 0;
      sclk_rises     = 0;
      ncs_low_cycles = 0;
      addr_at_fall   = adc_addr;
      last_high_run  = high_run;
      frames++;
    end
    if (prev_sclk && !adc_sclk && !adc_ncs) bit_idx++;
    if (!prev_sclk && adc_sclk && !adc_ncs) sclk_rises++;
    if ((adc_ncs != prev_ncs) || (adc_sclk != prev_sclk)) toggles++;
    if (!adc_ncs) begin
      ncs_low_cycles++;
      high_run = 0;
    end else begin
      high_run++;
    end
    fa = {2'b00, model_a, 2'b00};
    fb = {2'b00, model_b, 2'b00};
    adc_a = (!adc_ncs && bit_idx < 16) ? fa[15-bit_idx] : 1'b0;
    adc_b = (!adc_ncs && bit_idx < 16) ? fb[15-bit_idx] : 1'b0;
    prev_ncs  = adc_ncs;
    prev_sclk = adc_sclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One full transaction; rdy must be 1 on entry so the next edge accepts it.
  task automatic do_frame(input logic [2:0] a, input logic [11:0] da, input logic [11:0] db,
                          input bit tie, input int pulse_at, input string tag);
    int n;
    logic [23:0] exp;
    model_a = da;
    model_b = db;
    sb.push_back({da, db});
    req  = 1'b1;
    addr = a;
    step(1);
    if (!tie) req = 1'b0;
    check({tag, "_rdy_fall"}, 32'(rdy), 32'd0);
    n = 0;
    while (!rdy && n < 200) begin
      step(1);
      n++;
      if (pulse_at > 0 && n == pulse_at) begin
        req  = 1'b1;
        addr = 3'd4;
      end else if (pulse_at > 0 && n == pulse_at + 1) begin
        req = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    exp = sb.pop_front();
    check({tag, "_data_a"}, 32'(data_a), 32'(exp[23:12]));
    check({tag, "_data_b"}, 32'(data_b), 32'(exp[11:0]));
    check({tag, "_sclk_rises"}, 32'(sclk_rises), 32'd16);
    check({tag, "_ncs_low"}, 32'(ncs_low_cycles), 32'(32 * HP));
    check({tag, "_addr_at_ncs"}, 32'(addr_at_fall), 32'(a));
    $display("[TB] %s addr=%0d a=%03h/%03h b=%03h/%03h lat=%0d", tag, a,
             data_a, exp[23:12], data_b, exp[11:0], n);
    last_a = exp[23:12];
    last_b = exp[11:0];
  endtask

  logic [11:0] pats [3] = '{12'h000, 12'hFFF, 12'h800};

  initial begin
    int t0;
    int f0;
    int drops;
    logic [23:0] dropped;

    rst  = 1'b1;
    req  = 1'b0;
    addr = 3'd0;

    // 1: reset state
    step(5);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_ncs", 32'(adc_ncs), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd1);
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    check("rst_rng", 32'(adc_rng), 32'd0);
    check("rst_addr", 32'(adc_addr), 32'd0);
    rst = 1'b0;
    step(1);
    check("release_rdy", 32'(rdy), 32'd1);

    // 2: single conversion
    do_frame(3'd3, 12'hA5C, 12'h3F1, 1'b0, 0, "single");

    // 3: no-op addresses never start a frame
    t0 = toggles;
    drops = 0;
    req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      addr = (i < 50) ? 3'd0 : 3'd7;
      step(1);
      if (!rdy) drops++;
    end
    req = 1'b0;
    check("noop_rdy_drops", 32'(drops), 32'd0);
    check("noop_pin_toggles", 32'(toggles - t0), 32'd0);
    check("noop_data_a", 32'(data_a), 32'(last_a));
    check("noop_data_b", 32'(data_b), 32'(last_b));
    $display("[TB] noop drops=%0d toggles=%0d", drops, toggles - t0);

    // 4: back-to-back with req held high
    for (int i = 0; i < 16; i++) begin
      do_frame(3'd5, pats[i % 3], pats[(i + 1) % 3], 1'b1, 0, $sformatf("b2b%0d", i));
      if (i > 0) check($sformatf("b2b%0d_ncs_gap", i), 32'(last_high_run >= HP + QC), 32'd1);
    end
    req = 1'b0;
    step(2);

    // 5: reset in the middle of CONVERT
    model_a = 12'h123;
    model_b = 12'h456;
    sb.push_back({12'h123, 12'h456});
    req  = 1'b1;
    addr = 3'd1;
    step(1);
    req = 1'b0;
    for (int i = 0; i < 20 && adc_ncs; i++) step(1);
    check("abort_ncs_fell", 32'(adc_ncs), 32'd0);
    step(29);
    check("abort_cycle30", 32'(ncs_low_cycles), 32'd30);
    rst = 1'b1;
    step(1);
    dropped = sb.pop_front();
    check("abort_ncs", 32'(adc_ncs), 32'd1);
    check("abort_sclk", 32'(adc_sclk), 32'd1);
    check("abort_data_a", 32'(data_a), 32'd0);
    check("abort_data_b", 32'(data_b), 32'd0);
    $display("[TB] abort discarded a=%03h b=%03h", dropped[23:12], dropped[11:0]);
    rst = 1'b0;
    step(1);
    check("abort_release_rdy", 32'(rdy), 32'd1);
    do_frame(3'd2, 12'h5A5, 12'hC3C, 1'b0, 0, "after_abort");

    // 6: request pulsed while busy is ignored
    do_frame(3'd6, 12'h9E7, 12'h0B4, 1'b0, 20, "busy_pulse");
    check("busy_addr_held", 32'(adc_addr), 32'd6);
    f0 = frames;
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!rdy) drops++;
    end
    check("busy_no_extra_frame", 32'(frames - f0), 32'd0);
    check("busy_rdy_stays", 32'(drops), 32'd0);
    check("busy_data_a_held", 32'(data_a), 32'(last_a));
    $display("[TB] busy_pulse extra_frames=%0d", frames - f0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
